// File: rtl/id_issue_queue_pkg.sv
// id_issue_queue_pkg: shared widths, register-file constants and the
// load-scoreboard entry type used by the ID-stage issue queue.
// Latency: n/a (types and constants only). Backpressure: n/a.
package id_issue_queue_pkg;

  // Bus widths shared with the rest of the core.
  localparam int ADDR_BUS     = 32;
  localparam int INST_BUS     = 32;
  localparam int REG_ADDR_BUS = 5;

  // $zero is hard-wired; it can never be the subject of a load-use hazard.
  localparam logic [REG_ADDR_BUS-1:0] ZERO_REG = '0;

  // One scoreboard stage: a load destination still in flight.
  typedef struct packed {
    logic                    vld;
    logic [REG_ADDR_BUS-1:0] dst;
  } sb_entry_t;

  // Pointer width for a queue of the given depth.
  function automatic int idq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/idq_load_scoreboard.sv
// idq_load_scoreboard: LOAD_LAT-stage shift register of in-flight load
// destinations plus two read-address comparators.
// Latency: a load written at a clock edge is visible to the matchers in the
// next cycle. Backpressure: shifting is held while i_advance is low.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_flush         clears every stage
//   i_advance       shift enable (low while EX is stalled)
//   i_load_vld      a non-$zero load is issuing this cycle
//   i_load_dst      its destination register
//   i_rd_addr_1/2   decoder read addresses to compare
//   o_match_1/2     address equals a valid in-flight load destination
module idq_load_scoreboard
  import id_issue_queue_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic                    i_advance,
  input  logic                    i_load_vld,
  input  logic [REG_ADDR_BUS-1:0] i_load_dst,
  input  logic [REG_ADDR_BUS-1:0] i_rd_addr_1,
  input  logic [REG_ADDR_BUS-1:0] i_rd_addr_2,
  output logic                    o_match_1,
  output logic                    o_match_2
);

  sb_entry_t r_stage [LOAD_LAT];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_advance) begin
      // Stage 0 always reloads; a non-load cycle shifts in an empty bubble.
      r_stage[0].vld <= i_load_vld;
      r_stage[0].dst <= i_load_dst;
      for (int i = 1; i < LOAD_LAT; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  always_comb begin
    o_match_1 = 1'b0;
    o_match_2 = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      o_match_1 = o_match_1 | (r_stage[i].vld & (r_stage[i].dst == i_rd_addr_1));
      o_match_2 = o_match_2 | (r_stage[i].vld & (r_stage[i].dst == i_rd_addr_2));
    end
  end

endmodule

// File: rtl/id_issue_queue.sv
// id_issue_queue: DEPTH-entry IF->ID instruction FIFO with internal load-use
// hazard detection and wrong-path discard after a taken branch.
// Latency: a push is visible at the head the cycle after it is accepted.
// Backpressure: stall_request while full; a push into a full queue is dropped.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    CP0 exception/eret flush (empties queue + scoreboard)
//   ex_stall                 ID/EX cannot accept this cycle
//   push_*                   instruction delivered by IF
//   stall_request            queue full, IF must hold
//   id_valid/addr/inst/ds    head entry (zero when empty)
//   id_reg_* / id_mem_*      decoder information about the head
//   id_branch_flag           head is a taken branch/jump
//   issue                    head consumed this cycle
//   hazard_stall             head blocked by a load-use hazard
// Optional (IDQ_STATS_EN): stat_hazard_cycles, stat_full_cycles,
//   stat_branch_discards saturating event counters.
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int LOAD_LAT   = 1,
  parameter int ADDR_WIDTH = ADDR_BUS,
  parameter int INST_WIDTH = INST_BUS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    ex_stall,
  input  logic                    push_valid,
  input  logic [ADDR_WIDTH-1:0]   push_addr,
  input  logic [INST_WIDTH-1:0]   push_inst,
  input  logic                    push_delayslot,
  output logic                    stall_request,
  output logic                    id_valid,
  output logic [ADDR_WIDTH-1:0]   id_addr,
  output logic [INST_WIDTH-1:0]   id_inst,
  output logic                    id_delayslot,
  input  logic                    id_reg_read_en_1,
  input  logic [REG_ADDR_BUS-1:0] id_reg_addr_1,
  input  logic                    id_reg_read_en_2,
  input  logic [REG_ADDR_BUS-1:0] id_reg_addr_2,
  input  logic                    id_mem_read_flag,
  input  logic [REG_ADDR_BUS-1:0] id_reg_write_addr,
  input  logic                    id_branch_flag,
  output logic                    issue,
  output logic                    hazard_stall
`ifdef IDQ_STATS_EN
  ,
  output logic [31:0]             stat_hazard_cycles,
  output logic [31:0]             stat_full_cycles,
  output logic [31:0]             stat_branch_discards
`endif
);

  localparam int PTR_W = idq_ptr_w(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);

  logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
  logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
  logic                  r_ds_mem   [DEPTH];

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic w_not_empty;
  logic w_push_acc;
  logic w_branch_cut;
  logic w_mem_we;
  logic w_load_vld;
  logic w_match_1;
  logic w_match_2;

  // ---------------------------------------------------------------- head view
  assign w_not_empty   = (r_count != '0);
  assign stall_request = (r_count == CNT_FULL);
  assign id_valid      = w_not_empty;
  assign id_addr       = w_not_empty ? r_addr_mem[r_rd_ptr] : '0;
  assign id_inst       = w_not_empty ? r_inst_mem[r_rd_ptr] : '0;
  assign id_delayslot  = w_not_empty & r_ds_mem[r_rd_ptr];

  // ---------------------------------------------------------- hazard / issue
  idq_load_scoreboard #(
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_advance   (~ex_stall),
    .i_load_vld  (w_load_vld),
    .i_load_dst  (id_reg_write_addr),
    .i_rd_addr_1 (id_reg_addr_1),
    .i_rd_addr_2 (id_reg_addr_2),
    .o_match_1   (w_match_1),
    .o_match_2   (w_match_2)
  );

  assign hazard_stall = id_valid &
                        ((id_reg_read_en_1 & (id_reg_addr_1 != ZERO_REG) & w_match_1) |
                         (id_reg_read_en_2 & (id_reg_addr_2 != ZERO_REG) & w_match_2));

  assign issue      = id_valid & ~hazard_stall & ~ex_stall & ~flush;
  assign w_load_vld = issue & id_mem_read_flag & (id_reg_write_addr != ZERO_REG);

  // ------------------------------------------------------------- queue state
  assign w_push_acc = push_valid & ~stall_request & ~flush;

  // A taken branch with at least two entries keeps only the delay slot at
  // head+1. With a single entry the ordinary pop/push already leaves exactly
  // the delay slot (the same-cycle push, or nothing), so no special case.
  assign w_branch_cut = issue & id_branch_flag & (r_count >= CNT_TWO);
  assign w_mem_we     = w_push_acc & ~w_branch_cut;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= r_rd_ptr;
      r_count  <= '0;
    end else if (w_branch_cut) begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_wr_ptr <= r_rd_ptr + PTR_W'(2);
      r_count  <= (PTR_W+1)'(1);
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (issue)      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_push_acc) - (PTR_W+1)'(issue);
    end
  end

  // Payload storage needs no reset: reads are gated by r_count.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_addr_mem[r_wr_ptr] <= push_addr;
      r_inst_mem[r_wr_ptr] <= push_inst;
      r_ds_mem[r_wr_ptr]   <= push_delayslot;
    end
  end

`ifdef IDQ_STATS_EN
  // --------------------------------------------------------------- counters
  logic [31:0] r_stat_hazard;
  logic [31:0] r_stat_full;
  logic [31:0] r_stat_disc;
  logic [31:0] w_discards;

  // Entries lost on a branch cut: everything younger than the delay slot,
  // plus a push arriving in the same cycle.
  always_comb begin
    w_discards = '0;
    if (w_branch_cut) begin
      w_discards = 32'(r_count) - 32'd2 + 32'(w_push_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_hazard <= '0;
      r_stat_full   <= '0;
      r_stat_disc   <= '0;
    end else begin
      r_stat_hazard <= sat_add32(r_stat_hazard, 32'(hazard_stall));
      r_stat_full   <= sat_add32(r_stat_full, 32'(stall_request));
      r_stat_disc   <= sat_add32(r_stat_disc, w_discards);
    end
  end

  assign stat_hazard_cycles   = r_stat_hazard;
  assign stat_full_cycles     = r_stat_full;
  assign stat_branch_discards = r_stat_disc;
`endif

endmodule

// File: tb/tb_id_issue_queue.sv
// tb_id_issue_queue: directed vector table for the documented corner cases,
// followed by randomized traffic checked against a queue-based reference.
// Latency: n/a. Backpressure: n/a.
module tb_id_issue_queue;

  localparam int DEPTH    = 4;
  localparam int LOAD_LAT = 1;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_stall;
  logic        push_valid;
  logic [31:0] push_addr;
  logic [31:0] push_inst;
  logic        push_delayslot;
  logic        stall_request;
  logic        id_valid;
  logic [31:0] id_addr;
  logic [31:0] id_inst;
  logic        id_delayslot;
  logic        id_reg_read_en_1;
  logic [4:0]  id_reg_addr_1;
  logic        id_reg_read_en_2;
  logic [4:0]  id_reg_addr_2;
  logic        id_mem_read_flag;
  logic [4:0]  id_reg_write_addr;
  logic        id_branch_flag;
  logic        issue;
  logic        hazard_stall;
`ifdef IDQ_STATS_EN
  logic [31:0] stat_hazard_cycles;
  logic [31:0] stat_full_cycles;
  logic [31:0] stat_branch_discards;
`endif

  id_issue_queue #(
    .DEPTH      (DEPTH),
    .LOAD_LAT   (LOAD_LAT),
    .ADDR_WIDTH (32),
    .INST_WIDTH (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .ex_stall          (ex_stall),
    .push_valid        (push_valid),
    .push_addr         (push_addr),
    .push_inst         (push_inst),
    .push_delayslot    (push_delayslot),
    .stall_request     (stall_request),
    .id_valid          (id_valid),
    .id_addr           (id_addr),
    .id_inst           (id_inst),
    .id_delayslot      (id_delayslot),
    .id_reg_read_en_1  (id_reg_read_en_1),
    .id_reg_addr_1     (id_reg_addr_1),
    .id_reg_read_en_2  (id_reg_read_en_2),
    .id_reg_addr_2     (id_reg_addr_2),
    .id_mem_read_flag  (id_mem_read_flag),
    .id_reg_write_addr (id_reg_write_addr),
    .id_branch_flag    (id_branch_flag),
    .issue             (issue),
    .hazard_stall      (hazard_stall)
`ifdef IDQ_STATS_EN
    ,
    .stat_hazard_cycles   (stat_hazard_cycles),
    .stat_full_cycles     (stat_full_cycles),
    .stat_branch_discards (stat_branch_discards)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ------------------------------------------------------- directed table
  typedef struct {
    logic        rst, fl, exs, pv;
    logic [31:0] paddr;
    logic        re1;
    logic [4:0]  ra1;
    logic        ld;
    logic [4:0]  wa;
    logic        br;
    logic        e_v;
    logic [31:0] e_addr;
    logic        e_full, e_haz, e_iss;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t R(input logic rs, input logic fl, input logic exs, input logic pv,
                             input logic [31:0] pa, input logic re1, input logic [4:0] ra1,
                             input logic ld, input logic [4:0] wa, input logic br,
                             input logic ev, input logic [31:0] ea, input logic ef,
                             input logic eh, input logic ei);
    vec_t v;
    v.rst = rs; v.fl = fl; v.exs = exs; v.pv = pv; v.paddr = pa;
    v.re1 = re1; v.ra1 = ra1; v.ld = ld; v.wa = wa; v.br = br;
    v.e_v = ev; v.e_addr = ea; v.e_full = ef; v.e_haz = eh; v.e_iss = ei;
    return v;
  endfunction

  task automatic idle_inputs();
    rst = 0; flush = 0; ex_stall = 0; push_valid = 0; push_addr = 0; push_inst = 0;
    push_delayslot = 0; id_reg_read_en_1 = 0; id_reg_addr_1 = 0; id_reg_read_en_2 = 0;
    id_reg_addr_2 = 0; id_mem_read_flag = 0; id_reg_write_addr = 0; id_branch_flag = 0;
  endtask

  task automatic run_vec(input vec_t v);
    idle_inputs();
    rst = v.rst; flush = v.fl; ex_stall = v.exs; push_valid = v.pv;
    push_addr = v.paddr; push_inst = v.paddr ^ 32'hA5A5_0000;
    id_reg_read_en_1 = v.re1; id_reg_addr_1 = v.ra1;
    id_mem_read_flag = v.ld; id_reg_write_addr = v.wa; id_branch_flag = v.br;
    @(negedge clk);
    chk("tbl.id_valid", 64'(id_valid), 64'(v.e_v));
    chk("tbl.id_addr", 64'(id_addr), 64'(v.e_addr));
    chk("tbl.stall_request", 64'(stall_request), 64'(v.e_full));
    chk("tbl.hazard_stall", 64'(hazard_stall), 64'(v.e_haz));
    chk("tbl.issue", 64'(issue), 64'(v.e_iss));
    @(posedge clk); #1;
    cyc++;
  endtask

  // ------------------------------------------------------ reference model
  typedef struct {
    logic [31:0] a;
    logic [31:0] i;
    logic        ds;
  } ent_t;

  ent_t mq[$];     // queued instructions, oldest first
  int   ld_dst[$]; // in-flight load destinations
  int   ld_rem[$]; // EX-advancing cycles each one still blocks

  function automatic bit m_match(input logic [4:0] r);
    foreach (ld_dst[k]) if (ld_dst[k] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    bit          e_v, e_haz, e_iss, e_pacc, e_full;
    logic [31:0] e_addr, e_inst;
    logic        e_ds;
    ent_t        ne;

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;

    // rst, fl, exs, pv, paddr, re1, ra1, ld, wa, br | v, addr, full, haz, iss
    tbl.push_back(R(1,0,0,0,32'h0,         0,0,0,0,0, 0,32'h0,0,0,0));
    // fill with EX stalled; fifth push dropped, then drain in order
    tbl.push_back(R(0,0,1,1,32'hBFC00000,  0,0,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(R(0,0,1,1,32'hBFC00004,  0,0,0,0,0, 1,32'hBFC00000,0,0,0));
    tbl.push_back(R(0,0,1,1,32'hBFC00008,  0,0,0,0,0, 1,32'hBFC00000,0,0,0));
    tbl.push_back(R(0,0,1,1,32'hBFC0000C,  0,0,0,0,0, 1,32'hBFC00000,0,0,0));
    tbl.push_back(R(0,0,1,1,32'hBFC00010,  0,0,0,0,0, 1,32'hBFC00000,1,0,0));
    tbl.push_back(R(0,0,0,0,32'h0,         0,0,0,0,0, 1,32'hBFC00000,1,0,1));
    tbl.push_back(R(0,0,0,0,32'h0,         0,0,0,0,0, 1,32'hBFC00004,0,0,1));
    tbl.push_back(R(0,0,0,0,32'h0,         0,0,0,0,0, 1,32'hBFC00008,0,0,1));
    tbl.push_back(R(0,0,0,0,32'h0,         0,0,0,0,0, 1,32'hBFC0000C,0,0,1));
    tbl.push_back(R(0,0,0,0,32'h0,         0,0,0,0,0, 0,32'h0,0,0,0));
    // lw $8 then reader of $8: one hazard cycle
    tbl.push_back(R(0,0,0,1,32'h000000B0,  0,0,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(R(0,0,0,1,32'h000000B4,  0,0,1,8,0, 1,32'hB0,0,0,1));
    tbl.push_back(R(0,0,0,0,32'h0,         1,8,0,0,0, 1,32'hB4,0,1,0));
    tbl.push_back(R(0,0,0,0,32'h0,         1,8,0,0,0, 1,32'hB4,0,0,1));
    // lw $8 then EX stalled 3 cycles: hazard held, clears a cycle after release
    tbl.push_back(R(0,0,0,1,32'h000000B8,  0,0,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(R(0,0,0,1,32'h000000BC,  0,0,1,8,0, 1,32'hB8,0,0,1));
    tbl.push_back(R(0,0,1,0,32'h0,         1,8,0,0,0, 1,32'hBC,0,1,0));
    tbl.push_back(R(0,0,1,0,32'h0,         1,8,0,0,0, 1,32'hBC,0,1,0));
    tbl.push_back(R(0,0,1,0,32'h0,         1,8,0,0,0, 1,32'hBC,0,1,0));
    tbl.push_back(R(0,0,0,0,32'h0,         1,8,0,0,0, 1,32'hBC,0,1,0));
    tbl.push_back(R(0,0,0,0,32'h0,         1,8,0,0,0, 1,32'hBC,0,0,1));
    // lw $0 then reader of $0: never a hazard
    tbl.push_back(R(0,0,0,1,32'h000000C0,  0,0,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(R(0,0,0,1,32'h000000C4,  0,0,1,0,0, 1,32'hC0,0,0,1));
    tbl.push_back(R(0,0,0,0,32'h0,         1,0,0,0,0, 1,32'hC4,0,0,1));
    // count=3 with pending lw $9, flush + push: queue and scoreboard emptied
    tbl.push_back(R(0,0,1,1,32'h000000D0,  0,0,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(R(0,0,1,1,32'h000000D4,  0,0,0,0,0, 1,32'hD0,0,0,0));
    tbl.push_back(R(0,0,1,1,32'h000000D8,  0,0,0,0,0, 1,32'hD0,0,0,0));
    tbl.push_back(R(0,0,0,1,32'h000000DC,  0,0,1,9,0, 1,32'hD0,0,0,1));
    tbl.push_back(R(0,1,1,1,32'h000000E0,  1,9,0,0,0, 1,32'hD4,0,1,0));
    tbl.push_back(R(0,0,1,1,32'h000000E4,  0,0,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(R(0,0,0,0,32'h0,         1,9,0,0,0, 1,32'hE4,0,0,1));
    // branch at count=3 with same-cycle push: only the delay slot survives
    tbl.push_back(R(0,0,1,1,32'h000000F0,  0,0,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(R(0,0,1,1,32'h000000F4,  0,0,0,0,0, 1,32'hF0,0,0,0));
    tbl.push_back(R(0,0,1,1,32'h000000F8,  0,0,0,0,0, 1,32'hF0,0,0,0));
    tbl.push_back(R(0,0,0,1,32'h000000FC,  0,0,0,0,1, 1,32'hF0,0,0,1));
    tbl.push_back(R(0,0,0,0,32'h0,         0,0,0,0,0, 1,32'hF4,0,0,1));
    tbl.push_back(R(0,0,0,0,32'h0,         0,0,0,0,0, 0,32'h0,0,0,0));
    // branch at count=1 with same-cycle push: the push is the delay slot
    tbl.push_back(R(0,0,0,1,32'h00000100,  0,0,0,0,0, 0,32'h0,0,0,0));
    tbl.push_back(R(0,0,0,1,32'h00000104,  0,0,0,0,1, 1,32'h100,0,0,1));
    tbl.push_back(R(0,0,0,0,32'h0,         0,0,0,0,0, 1,32'h104,0,0,1));
    tbl.push_back(R(0,0,0,0,32'h0,         0,0,0,0,0, 0,32'h0,0,0,0));

    foreach (tbl[k]) run_vec(tbl[k]);

    // Hand sequence: branch at count=1 with no push; next push is kept.
    idle_inputs(); push_valid = 1; push_addr = 32'h200; @(posedge clk); #1; cyc++;
    idle_inputs(); id_branch_flag = 1;
    @(negedge clk); chk("seq.br1_issue", 64'(issue), 64'd1);
    @(posedge clk); #1; cyc++;
    idle_inputs();
    @(negedge clk); chk("seq.br1_empty", 64'(id_valid), 64'd0);
    push_valid = 1; push_addr = 32'h204;
    @(posedge clk); #1; cyc++;
    idle_inputs();
    @(negedge clk); chk("seq.br1_slot", 64'(id_addr), 64'h204);
    @(posedge clk); #1; cyc++;

    // ---------------------------------------------------- randomized phase
    idle_inputs(); rst = 1; @(posedge clk); #1; cyc++;
    mq.delete(); ld_dst.delete(); ld_rem.delete();
    for (int t = 0; t < 4000; t++) begin
      idle_inputs();
      rst               = ($urandom_range(0, 299) == 0);
      flush             = ($urandom_range(0, 24) == 0);
      ex_stall          = ($urandom_range(0, 3) == 0);
      push_valid        = ($urandom_range(0, 3) != 0);
      push_addr         = $urandom;
      push_inst         = $urandom;
      push_delayslot    = 1'($urandom_range(0, 1));
      id_reg_read_en_1  = 1'($urandom_range(0, 1));
      id_reg_addr_1     = 5'($urandom_range(0, 3));
      id_reg_read_en_2  = 1'($urandom_range(0, 1));
      id_reg_addr_2     = 5'($urandom_range(0, 3));
      id_mem_read_flag  = ($urandom_range(0, 2) == 0);
      id_reg_write_addr = 5'($urandom_range(0, 3));
      id_branch_flag    = ($urandom_range(0, 5) == 0);

      e_v    = (mq.size() > 0);
      e_addr = e_v ? mq[0].a : 32'h0;
      e_inst = e_v ? mq[0].i : 32'h0;
      e_ds   = e_v ? mq[0].ds : 1'b0;
      e_full = (mq.size() == DEPTH);
      e_haz  = e_v && ((id_reg_read_en_1 && id_reg_addr_1 != 0 && m_match(id_reg_addr_1)) ||
                       (id_reg_read_en_2 && id_reg_addr_2 != 0 && m_match(id_reg_addr_2)));
      e_iss  = e_v && !e_haz && !ex_stall && !flush;
      e_pacc = push_valid && !e_full && !flush;

      @(negedge clk);
      chk("rnd.id_valid", 64'(id_valid), 64'(e_v));
      chk("rnd.id_addr", 64'(id_addr), 64'(e_addr));
      chk("rnd.id_inst", 64'(id_inst), 64'(e_inst));
      chk("rnd.id_delayslot", 64'(id_delayslot), 64'(e_ds));
      chk("rnd.stall_request", 64'(stall_request), 64'(e_full));
      chk("rnd.hazard_stall", 64'(hazard_stall), 64'(e_haz));
      chk("rnd.issue", 64'(issue), 64'(e_iss));
      @(posedge clk);

      if (rst || flush) begin
        mq.delete(); ld_dst.delete(); ld_rem.delete();
      end else begin
        if (!ex_stall) begin
          for (int k = ld_rem.size() - 1; k >= 0; k--) begin
            ld_rem[k] = ld_rem[k] - 1;
            if (ld_rem[k] == 0) begin
              ld_rem.delete(k);
              ld_dst.delete(k);
            end
          end
        end
        if (e_iss && id_mem_read_flag && id_reg_write_addr != 0) begin
          ld_dst.push_back(int'(id_reg_write_addr));
          ld_rem.push_back(LOAD_LAT);
        end
        if (e_iss && id_branch_flag && mq.size() >= 2) begin
          ne = mq[1];
          mq.delete();
          mq.push_back(ne);
        end else begin
          if (e_iss) void'(mq.pop_front());
          if (e_pacc) begin
            ne.a = push_addr; ne.i = push_inst; ne.ds = push_delayslot;
            mq.push_back(ne);
          end
        end
      end
      #1;
      cyc++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_issue_queue.md
Name: id_issue_queue

Overview:
- Parametrised front end for the ID stage. It sits between IF and ID, buffering fetched instructions in a DEPTH-entry FIFO.
- Presents the head instruction to the ID decoder and detects load-use hazards with an internal load scoreboard. This replaces the external load_related_1/2 inputs.
- Discards wrong-path entries after a branch while keeping the delay slot. Drives stall_request back to IF when full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- LOAD_LAT, 1, cycles a load destination stays unavailable after issue; at least 1.
- ADDR_WIDTH, 32, width of the PC field.
- INST_WIDTH, 32, width of the instruction field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  exception/eret flush from CP0
- ex_stall  in  1  downstream stall (ID/EX cannot accept)
- push_valid  in  1  IF delivers an instruction this cycle
- push_addr  in  ADDR_WIDTH  PC of the pushed instruction
- push_inst  in  INST_WIDTH  pushed instruction word
- push_delayslot  in  1  delayslot flag of the pushed instruction
- stall_request  out  1  queue full; IF holds
- id_valid  out  1  head entry valid
- id_addr  out  ADDR_WIDTH  head PC
- id_inst  out  INST_WIDTH  head instruction
- id_delayslot  out  1  head delayslot flag
- id_reg_read_en_1  in  1  decoder read enable, channel 1 (for the head)
- id_reg_addr_1  in  5  decoder read address, channel 1
- id_reg_read_en_2  in  1  decoder read enable, channel 2
- id_reg_addr_2  in  5  decoder read address, channel 2
- id_mem_read_flag  in  1  head is a load
- id_reg_write_addr  in  5  head destination register
- id_branch_flag  in  1  head is a taken branch/jump
- issue  out  1  head consumed this cycle
- hazard_stall  out  1  head blocked by load-use hazard

Behaviour:
- Reset (rst=1 at posedge):
  - count, read/write pointers and all scoreboard entries clear to 0.
  - id_valid, stall_request, hazard_stall and issue read 0.
  - id_addr, id_inst and id_delayslot read 0.
  - Any operation in progress is abandoned.
- Outputs:
  - id_* are combinational views of the head entry, gated to 0 when count=0.
  - stall_request = (count==DEPTH), decoded from the registered count.
- Hazard and issue:
  - hazard_stall = id_valid & ((id_reg_read_en_1 & id_reg_addr_1!=0 & match(id_reg_addr_1)) | (same for channel 2)).
  - match(r) is true when any valid scoreboard entry holds r.
  - issue = id_valid & ~hazard_stall & ~ex_stall & ~flush.
- Push:
  - Accepted iff push_valid & ~stall_request & ~flush.
  - A push into a full queue is dropped; IF is responsible for holding.
  - Simultaneous push and issue is legal at any count below DEPTH.
- Pointers wrap modulo DEPTH. count is updated as count + push_accepted - issue, except in the cases below.
- Branch issue (issue & id_branch_flag): the next state keeps exactly one entry, the delay slot.
  - If count at least 2: retain the entry at head+1 and drop all younger entries. A push in the same cycle is dropped.
  - If count is 1 and a push is accepted in the same cycle: the push is the delay slot and is retained (count becomes 1).
  - If count is 1 and there is no push: count becomes 0. The next accepted push is the delay slot.
- Flush has highest priority:
  - count becomes 0 and the scoreboard clears.
  - A same-cycle push is dropped and issue is 0.
- Scoreboard is a LOAD_LAT-stage shift register of {valid, reg[4:0]}.
  - On issue & id_mem_read_flag & id_reg_write_addr!=0, stage 0 loads {1, id_reg_write_addr}. Otherwise stage 0 loads valid=0.
  - The shift advances only when ex_stall=0, so loads stalled in EX keep blocking.
  - Entries drop out after stage LOAD_LAT-1.
- A hazard on $zero never stalls.

Optional Feature:
- Macro IDQ_STATS_EN.
- When defined, add outputs stat_hazard_cycles[31:0], stat_full_cycles[31:0] and stat_branch_discards[31:0]:
  - stat_hazard_cycles increments on each cycle with hazard_stall=1.
  - stat_full_cycles increments on each cycle with stall_request=1.
  - stat_branch_discards increments by the number of entries dropped on a branch issue, counting a same-cycle push.
  - All three clear on rst (not on flush) and saturate at all-ones.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared header bus.v supplies ADDR_BUS, INST_BUS and REG_ADDR_BUS.
- Add IDQ_PTR_W (log2 DEPTH) and the zero-register constant to a new idq.v include.
- One sub-module: idq_load_scoreboard, holding the LOAD_LAT shift register and the two-address match logic.

Test Plan:
- Fill and drain: ex_stall=1, push 0xBFC00000..0xBFC0000C (4 entries) -> stall_request=1 after the 4th push, a 5th push of 0xBFC00010 is dropped. Drop ex_stall -> issue order 00, 04, 08, 0C, then id_valid=0.
- Load-use, LOAD_LAT=1: issue lw with write_addr=8, next head reads rs=8 -> hazard_stall=1 for exactly 1 cycle, issue on the next cycle.
- Load-use with ex_stall: lw $8 issued, then ex_stall=1 for 3 cycles -> hazard_stall held all 3 cycles and clears 1 cycle after ex_stall drops.
- Branch, count=3: queue {B, D, X}, push Y in the same cycle, B issues with id_branch_flag -> next cycle count=1 with head D; X and Y are gone.
- Branch, count=1: queue {B}, push D in the same cycle, B issues with id_branch_flag -> next cycle count=1 with head D.
- Flush and $zero: count=3 with a pending load, flush=1 plus a push -> next cycle id_valid=0, count=0, scoreboard clear. Then lw $0 followed by a reader of $0 -> no hazard_stall.
